// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared lane width, lane count and frame type for the sorter path
package sort_pkg;

    localparam int SORT_W     = 4;
    localparam int SORT_LANES = 4;

    typedef logic [SORT_LANES-1:0][SORT_W-1:0] sort_frame_t;

    localparam logic [SORT_W-1:0] SORT_PAD_DEFAULT = 4'hF;

endpackage

// File: rtl/sort_frame_outreg.sv
// rtl/sort_frame_outreg.sv - single-entry frame output register with delivered-frame counter
// Optional padded-frame flag port with SORT_COLLECT_FLUSH_EN.
module sort_frame_outreg
    import sort_pkg::*;
#(
    parameter int W = SORT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [SORT_LANES-1:0][W-1:0]   load_frame,
`ifdef SORT_COLLECT_FLUSH_EN
    input  logic                           load_padded,
    output logic                           m_padded,
`endif
    input  logic                           m_ready,
    output logic                           m_valid,
    output logic [SORT_LANES-1:0][W-1:0]   frame,
    output logic [7:0]                     frame_cnt
);

    // load is only raised when the register is empty or draining this cycle,
    // so a stalled frame is never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            frame     <= '0;
            frame_cnt <= 8'd0;
`ifdef SORT_COLLECT_FLUSH_EN
            m_padded  <= 1'b0;
`endif
        end else begin
            if (m_valid && m_ready)
                frame_cnt <= frame_cnt + 8'd1;
            if (load) begin
                m_valid  <= 1'b1;
                frame    <= load_frame;
`ifdef SORT_COLLECT_FLUSH_EN
                m_padded <= load_padded;
`endif
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sort_frame_collector.sv
// rtl/sort_frame_collector.sv - packs four serial samples into a frame for the four-input sorter
// Partial-frame flush with PAD fill is built with SORT_COLLECT_FLUSH_EN.
module sort_frame_collector
    import sort_pkg::*;
#(
    parameter int           W   = SORT_W,
    parameter logic [W-1:0] PAD = SORT_PAD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_a,
    output logic [W-1:0] m_b,
    output logic [W-1:0] m_c,
    output logic [W-1:0] m_d,
`ifdef SORT_COLLECT_FLUSH_EN
    input  logic         flush,
    output logic         m_padded,
`endif
    output logic [7:0]   frame_cnt
);

    logic [SORT_LANES-1:0][W-1:0] slots;
    logic [SORT_LANES-1:0][W-1:0] frame;
    logic [2:0]                   cnt;
    logic [2:0]                   cnt_acc;
    logic                         transfer;
    logic                         accept;
`ifdef SORT_COLLECT_FLUSH_EN
    logic                         asm_padded;
    logic                         flush_pad;
`endif

    always_comb begin
        transfer = (cnt == 3'd4) && (!m_valid || m_ready);
        s_ready  = (cnt != 3'd4) || transfer;
        accept   = s_valid && s_ready;
        cnt_acc  = cnt + {2'b00, accept};
`ifdef SORT_COLLECT_FLUSH_EN
        // A sample arriving with the flush that completes the frame wins; no padding then.
        flush_pad = flush && (cnt != 3'd0) && (cnt != 3'd4) && (cnt_acc != 3'd4);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 3'd0;
            slots <= '0;
`ifdef SORT_COLLECT_FLUSH_EN
            asm_padded <= 1'b0;
`endif
        end else if (transfer) begin
            cnt <= accept ? 3'd1 : 3'd0;
            if (accept)
                slots[0] <= s_data;
`ifdef SORT_COLLECT_FLUSH_EN
            asm_padded <= 1'b0;
`endif
        end else begin
            if (accept)
                slots[cnt[1:0]] <= s_data;
            cnt <= cnt_acc;
`ifdef SORT_COLLECT_FLUSH_EN
            if (flush_pad) begin
                for (int i = 0; i < SORT_LANES; i++)
                    if (3'(i) >= cnt_acc)
                        slots[i] <= PAD;
                cnt        <= 3'd4;
                asm_padded <= 1'b1;
            end
`endif
        end
    end

    sort_frame_outreg #(.W(W)) u_outreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (transfer),
        .load_frame  (slots),
`ifdef SORT_COLLECT_FLUSH_EN
        .load_padded (asm_padded),
        .m_padded    (m_padded),
`endif
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .frame       (frame),
        .frame_cnt   (frame_cnt)
    );

    assign m_a = frame[0];
    assign m_b = frame[1];
    assign m_c = frame[2];
    assign m_d = frame[3];

endmodule

// File: tb/tb_sort_frame_collector.sv
// tb/tb_sort_frame_collector.sv - randomized bench for sort_frame_collector against a queue model
module tb_sort_frame_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] s_data = 4'd0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [3:0] m_a, m_b, m_c, m_d;
    logic [7:0] frame_cnt;
`ifdef SORT_COLLECT_FLUSH_EN
    logic       flush = 1'b0;
    logic       m_padded;
`endif

    int total = 0;
    int bad   = 0;

    // model: samples not yet in the output register, plus the output register itself
    logic [3:0] asm_q[$];
    bit         asm_pad_e;
    logic [3:0] out_e[4];
    bit         out_pad_e;
    bit         mv_e;
    logic [7:0] fc_e;

    sort_frame_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_c       (m_c),
        .m_d       (m_d),
`ifdef SORT_COLLECT_FLUSH_EN
        .flush     (flush),
        .m_padded  (m_padded),
`endif
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        asm_q.delete();
        asm_pad_e = 1'b0;
        out_pad_e = 1'b0;
        mv_e      = 1'b0;
        fc_e      = 8'd0;
        for (int i = 0; i < 4; i++) out_e[i] = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
`ifdef SORT_COLLECT_FLUSH_EN
        flush = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_lanes", {m_a, m_b, m_c, m_d}, 0);
        check("rst_s_ready", s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic cycle(input bit sv, input logic [3:0] sd, input bit mr, input bit fl);
        bit rdy_e, acc, hs, xfer;
        int pre;
        @(negedge clk);
        check("m_valid", m_valid, mv_e);
        check("frame_cnt", frame_cnt, fc_e);
        if (mv_e) begin
            check("lanes", {m_a, m_b, m_c, m_d}, {out_e[0], out_e[1], out_e[2], out_e[3]});
`ifdef SORT_COLLECT_FLUSH_EN
            check("m_padded", m_padded, out_pad_e);
`endif
        end
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
`ifdef SORT_COLLECT_FLUSH_EN
        flush = fl;
`endif
        #1;
        rdy_e = (asm_q.size() < 4) || !mv_e || mr;
        check("s_ready", s_ready, rdy_e);
        pre  = asm_q.size();
        acc  = sv && rdy_e;
        hs   = mv_e && mr;
        xfer = (pre == 4) && (!mv_e || mr);
        if (hs) fc_e = fc_e + 8'd1;
        if (xfer) begin
            for (int i = 0; i < 4; i++) out_e[i] = asm_q[i];
            out_pad_e = asm_pad_e;
            asm_q.delete();
            asm_pad_e = 1'b0;
            mv_e = 1'b1;
        end else if (hs) begin
            mv_e = 1'b0;
        end
        if (acc) asm_q.push_back(sd);
`ifdef SORT_COLLECT_FLUSH_EN
        if (fl && pre >= 1 && pre <= 3 && asm_q.size() < 4) begin
            while (asm_q.size() < 4) asm_q.push_back(4'hF);
            asm_pad_e = 1'b1;
        end
`else
        if (fl) asm_pad_e = asm_pad_e;
`endif
    endtask

    initial begin
        logic [3:0] seq[4];
        model_clear();
        do_reset();

        // first frame 3,9,1,7 with consumer ready
        seq = '{4'd3, 4'd9, 4'd1, 4'd7};
        for (int i = 0; i < 4; i++) cycle(1, seq[i], 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);

        // back-to-back stream of 16 samples
        for (int i = 0; i < 16; i++) cycle(1, 4'($urandom), 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);

        // back-pressure: one frame stalls, eight samples offered, then release
        for (int i = 0; i < 4; i++) cycle(1, 4'($urandom), 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 4'($urandom), 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);

        // run long enough for frame_cnt to wrap past 255
        for (int i = 0; i < 1100; i++) cycle(1, 4'($urandom), 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);

        // reset mid-frame discards 5,6
        cycle(1, 4'd5, 1, 0);
        cycle(1, 4'd6, 1, 0);
        do_reset();
        seq = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 4; i++) cycle(1, seq[i], 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);

`ifdef SORT_COLLECT_FLUSH_EN
        cycle(1, 4'd5, 1, 0);
        cycle(1, 4'd6, 1, 0);
        cycle(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 4'($urandom), 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
`endif

        // randomized traffic with occasional stalls and flushes
        for (int i = 0; i < 800; i++)
            cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) != 0, ($urandom % 12) == 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
